// File: rtl/wall_clock_pkg.sv
// wall_clock_pkg: shared limits, field widths and BCD helpers for the
// wall_clock time-of-day counter.
//   SEC_MAX / MIN_MAX / HOUR_MAX : last legal value of each field
//   SEC_W / MIN_W / HOUR_W       : binary field widths
//   bcd_digit_t / bcd_pair_t     : BCD digit and tens/ones pair
//   to_bcd2()                    : binary 0..63 to a tens/ones BCD pair
package wall_clock_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd_pair_t;

    // Constant-divisor split; every field fits in 6 bits.
    function automatic bcd_pair_t to_bcd2(input logic [5:0] v);
        bcd_pair_t r;
        r.tens = bcd_digit_t'(v / 6'd10);
        r.ones = bcd_digit_t'(v % 6'd10);
        return r;
    endfunction

endpackage

// File: rtl/wall_clock_mod_counter.sv
// mod_counter: modulo-N up-counter with asynchronous active-low reset.
//   clk_i   : clock
//   rst_ni  : async active-low reset, value -> 0
//   inc_i   : advance by one on this edge
//   value_o : registered count 0..N-1
//   carry_o : combinational, high when an increment wraps the count to 0
// Any value >= N-1 is treated as the last value, so an illegal count
// recovers to 0 on its next increment.
module mod_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] value_o,
    output logic         carry_o
);
    import wall_clock_pkg::*;

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] value_q, value_d;
    logic         at_last;

    assign at_last = (value_q >= LAST);

    always_comb begin
        value_d = value_q;
        if (inc_i) begin
            value_d = at_last ? '0 : value_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) value_q <= '0;
        else         value_q <= value_d;
    end

    assign value_o = value_q;
    assign carry_o = inc_i & at_last;

endmodule

// File: rtl/wall_clock.sv
// wall_clock: 24-hour hh:mm:ss counter advanced by a 1 Hz clock, with
// manual minute/hour advance inputs.
//   Clock_1s   : time-base clock, one rising edge per second
//   reset      : async active-low, time -> 00:00:00
//   en         : count enable for seconds (and therefore all carries)
//   set_min    : advance minutes by one, no carry into hours
//   set_hour   : advance hours by one
//   seconds    : 0..59, minutes : 0..59, hours : 0..23
//   rollover   : one-cycle pulse after a natural 23:59:59 -> 00:00:00
//   bcd_digits : (only with WALL_CLOCK_BCD_EN) Htens,Hones,Mtens,Mones,
//                Stens,Sones, derived combinationally from the fields
module wall_clock
    import wall_clock_pkg::*;
(
    input  logic              Clock_1s,
    input  logic              reset,
    input  logic              en,
    input  logic              set_min,
    input  logic              set_hour,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
`ifdef WALL_CLOCK_BCD_EN
    output logic [23:0]       bcd_digits,
`endif
    output logic              rollover
);

    logic sec_co, min_co, hour_co;
    logic min_inc, hour_inc, hour_carry;
    logic rollover_q, rollover_d;

    // A set request and a natural carry into the same field collapse into
    // one increment. A wrap caused by set_min must not ripple into hours,
    // so the minute carry is only honoured when it came from seconds.
    assign min_inc    = set_min | sec_co;
    assign hour_carry = min_co & ~set_min;
    assign hour_inc   = set_hour | hour_carry;

    // Only a purely natural hour wrap counts as a day rollover.
    assign rollover_d = hour_co & ~set_hour;

    mod_counter #(.N(SEC_MAX + 1), .W(SEC_W)) u_sec (
        .clk_i   (Clock_1s),
        .rst_ni  (reset),
        .inc_i   (en),
        .value_o (seconds),
        .carry_o (sec_co)
    );

    mod_counter #(.N(MIN_MAX + 1), .W(MIN_W)) u_min (
        .clk_i   (Clock_1s),
        .rst_ni  (reset),
        .inc_i   (min_inc),
        .value_o (minutes),
        .carry_o (min_co)
    );

    mod_counter #(.N(HOUR_MAX + 1), .W(HOUR_W)) u_hour (
        .clk_i   (Clock_1s),
        .rst_ni  (reset),
        .inc_i   (hour_inc),
        .value_o (hours),
        .carry_o (hour_co)
    );

    always_ff @(posedge Clock_1s or negedge reset) begin
        if (!reset) rollover_q <= 1'b0;
        else        rollover_q <= rollover_d;
    end

    assign rollover = rollover_q;

`ifdef WALL_CLOCK_BCD_EN
    bcd_pair_t h_bcd, m_bcd, s_bcd;
    assign h_bcd      = to_bcd2({1'b0, hours});
    assign m_bcd      = to_bcd2(minutes);
    assign s_bcd      = to_bcd2(seconds);
    assign bcd_digits = {h_bcd, m_bcd, s_bcd};
`endif

endmodule

// File: tb/tb_wall_clock.sv
// tb_wall_clock: randomized and directed stimulus for wall_clock, checked
// against a behavioural time-of-day model (plain integer arithmetic).
// Builds with or without WALL_CLOCK_BCD_EN.
module tb_wall_clock;

    logic       Clock_1s = 1'b0;
    logic       reset, en, set_min, set_hour;
    logic [5:0] seconds, minutes;
    logic [4:0] hours;
    logic       rollover;
`ifdef WALL_CLOCK_BCD_EN
    logic [23:0] bcd_digits;
`endif

    bit run = 1'b0;
    int checks = 0;
    int errors = 0;

    // reference model state
    int ms = 0, mm = 0, mh = 0;
    bit mroll = 1'b0;

    always #5 if (run) Clock_1s = ~Clock_1s;

    wall_clock dut (
        .Clock_1s (Clock_1s),
        .reset    (reset),
        .en       (en),
        .set_min  (set_min),
        .set_hour (set_hour),
        .seconds  (seconds),
        .minutes  (minutes),
        .hours    (hours),
`ifdef WALL_CLOCK_BCD_EN
        .bcd_digits (bcd_digits),
`endif
        .rollover (rollover)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sec"}, 32'(seconds), ms);
        chk({tag, ".min"}, 32'(minutes), mm);
        chk({tag, ".hour"}, 32'(hours), mh);
        chk({tag, ".roll"}, 32'(rollover), 32'(mroll));
`ifdef WALL_CLOCK_BCD_EN
        chk({tag, ".bcd"}, 32'(bcd_digits),
            32'(((mh / 10) << 20) | ((mh % 10) << 16) | ((mm / 10) << 12) |
                ((mm % 10) << 8) | ((ms / 10) << 4) | (ms % 10)));
`endif
    endtask

    // One second of wall-clock behaviour, written from the field rules.
    task automatic model_step(input bit e, input bit sm, input bit sh);
        bit sc = 0, mc = 0, hc = 0;
        if (e) begin
            sc = (ms == 59);
            ms = (ms + 1) % 60;
        end
        if (sm) mm = (mm + 1) % 60;
        else if (sc) begin
            mc = (mm == 59);
            mm = (mm + 1) % 60;
        end
        if (sh) mh = (mh + 1) % 24;
        else if (mc) begin
            hc = (mh == 23);
            mh = (mh + 1) % 24;
        end
        mroll = hc;
    endtask

    // Drive, take one edge, then compare 1 time unit after the edge.
    task automatic step(input bit e, input bit sm, input bit sh, input string tag);
        en = e; set_min = sm; set_hour = sh;
        @(posedge Clock_1s);
        #1;
        model_step(e, sm, sh);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        ms = 0; mm = 0; mh = 0; mroll = 0;
        check_all(tag);
        reset = 1'b1;
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        do_reset("goto_rst");
        repeat (h) step(0, 0, 1, "goto_h");
        repeat (m) step(0, 1, 0, "goto_m");
        repeat (s) step(1, 0, 0, "goto_s");
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; set_min = 1'b0; set_hour = 1'b0;

        // reset with no clock edges at all
        #2;
        check_all("por");
        reset = 1'b1;
        run = 1'b1;

        // 75 enabled edges
        repeat (75) step(1, 0, 0, "cnt");
        chk("t75.sec", 32'(seconds), 15);
        chk("t75.min", 32'(minutes), 1);
        chk("t75.hour", 32'(hours), 0);

        // day rollover
        goto_time(23, 59, 58);
        step(1, 0, 0, "pre59");
        chk("pre59.sec", 32'(seconds), 59);
        step(1, 0, 0, "wrap");
        chk("wrap.roll", 32'(rollover), 1);
        chk("wrap.hour", 32'(hours), 0);
        step(1, 0, 0, "post_wrap");
        chk("post_wrap.roll", 32'(rollover), 0);

        // hold with en=0, then manual sets
        goto_time(12, 34, 56);
        repeat (10) step(0, 0, 0, "hold");
        chk("hold.sec", 32'(seconds), 56);
        step(0, 1, 0, "setm");
        chk("setm.min", 32'(minutes), 35);
        step(0, 0, 1, "seth");
        chk("seth.hour", 32'(hours), 13);

        // set_min wrap must not carry into hours
        goto_time(5, 59, 30);
        step(1, 1, 0, "mwrap");
        chk("mwrap.hour", 32'(hours), 5);
        chk("mwrap.min", 32'(minutes), 0);
        chk("mwrap.sec", 32'(seconds), 31);

        // set and natural carry on the same edge advance once
        goto_time(7, 14, 59);
        step(1, 1, 0, "absorb");
        chk("absorb.min", 32'(minutes), 15);

        // set_hour at 23:59:59 with a natural carry is not a rollover
        goto_time(23, 59, 59);
        step(1, 0, 1, "sethwrap");
        chk("sethwrap.roll", 32'(rollover), 0);

        // both sets together
        goto_time(3, 59, 0);
        step(0, 1, 1, "both");

        // randomized run
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) do_reset("rnd_rst");
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, "rnd");
        end

        // async reset mid-cycle
        goto_time(18, 22, 9);
`ifdef WALL_CLOCK_BCD_EN
        chk("pre_rst.bcd", 32'(bcd_digits), 32'h182209);
`endif
        chk("pre_rst.hour", 32'(hours), 18);
        #2;
        do_reset("mid_rst");
        chk("mid_rst.sec", 32'(seconds), 0);
`ifdef WALL_CLOCK_BCD_EN
        chk("mid_rst.bcd", 32'(bcd_digits), 0);
`endif
        step(1, 0, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // absolute bound so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout got 0x0 want 0x1");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
